fetch_stage: RTL

//  IF stage of the 5-stage RV32I pipeline: holds the PC, addresses instruction memory,

---
 rtl/fetch_stage.sv | 61 ++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage of the RV32I pipeline: owns the fetch PC, drives instruction memory and
// registers the fetched word with its PC and PC+4 into the IF/ID pipeline register.
module fetch_stage #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc_f,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] pc_target_aligned;

    // Plain XLEN-bit addition wraps modulo 2^XLEN, so 0xFFFFFFFC steps to 0.
    assign pc_plus4_f        = pc_f + PC_STEP;
    assign pc_target_aligned = {pc_target_e[XLEN-1:2], 2'b00};
    assign imem_addr         = pc_f;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, which lets the IF/ID register capture the old pc_f.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f <= RESET_PC;
        end else if (pc_src_e) begin
            pc_f <= pc_target_aligned;
        end else if (!stall_f) begin
            pc_f <= pc_plus4_f;
        end
    end

    // A flush beats a stall so a redirect always kills the wrong-path word.
    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (!stall_d) begin
            instr_d    <= imem_rdata;
            pc_d       <= pc_f;
            pc_plus4_d <= pc_plus4_f;
            valid_d    <= 1'b1;
        end
    end

endmodule
